alu_share_arb: RTL and testbench
================================

Name: alu_share_arb

Overview:
- Shares one combinational ALU between NREQ requesters, e.g. the execute stage and a debug/FPGA switch front end.
- Round-robin arbitration with a per-requester valid/ack response handshake.
- Registers ALU operands, lets the ALU settle for one cycle, captures the result and flags, and holds them until the owning requester acknowledges.
- Sits beside the alu instance and drives its ports. No other block drives the ALU while this arbiter is present.

Parameters:
- NREQ, 2: number of requesters; legal range 2..8.
- TIMEOUT, 15: cycles to wait for rsp_ack before abandoning a response. Used only with ALU_ARB_TIMEOUT_EN.

Ports:
- CLK  in  1  system clock.
- nRST  in  1  reset; synchronous, active-low.
- req  in  NREQ  level request, one bit per requester.
- req_op  in  NREQ x aluop_t  operation per requester.
- req_a  in  NREQ x word_t  operand A per requester.
- req_b  in  NREQ x word_t  operand B per requester.
- gnt  out  NREQ  one-hot, one-cycle grant pulse; operands are captured in this cycle.
- rsp_valid  out  NREQ  one-hot; response pending for that requester.
- rsp_ack  in  NREQ  response accept.
- rsp_data  out  word_t  result.
- rsp_neg, rsp_ovf, rsp_zero  out  1 each  ALU flags.
- busy  out  1  high when state is not IDLE.
- alu_op  out  aluop_t  to ALU.
- alu_a, alu_b  out  word_t  to ALU.
- alu_out  in  word_t  from ALU.
- alu_neg, alu_ovf, alu_zero  in  1 each  from ALU.
- err  out  1  sticky timeout flag; tied 0 when the optional feature is out.

Behaviour:
- Reset (nRST low at a CLK edge), applies at any point including mid-operation:
  - state goes to IDLE; round-robin pointer goes to 0.
  - gnt, rsp_valid, rsp_data, all rsp flags, alu_a, alu_b, busy and err go to 0.
  - alu_op goes to 4'h0.
  - Any in-flight response is discarded.
- State IDLE:
  - If any req is high, pick the first requester at or after the pointer, wrapping modulo NREQ.
  - In that same cycle: gnt[i] is high, alu_op/alu_a/alu_b load from requester i, and state goes to EXEC.
  - With no req high, stay in IDLE; ALU port registers hold their previous values.
- State EXEC (one cycle):
  - The ALU settles.
  - At the closing edge, rsp_data and flags capture alu_out and the alu flags, rsp_valid[i] is set, and state goes to RESP.
- State RESP:
  - rsp_valid[i], rsp_data and the flags are held stable until rsp_ack[i] is sampled high.
  - On that edge: rsp_valid clears, the pointer becomes (i+1) mod NREQ, and state goes to IDLE.
- Latency: grant at cycle t, rsp_valid first visible at t+2. Minimum grant-to-grant spacing is 3 cycles, i.e. one IDLE bubble after each ack.
- Boundary conditions:
  - rsp_ack on a bit other than the granted index, or in any state other than RESP: ignored.
  - rsp_ack asserted in the same cycle as rsp_valid first rises: accepted.
  - A requester may drop req after gnt. req changes outside IDLE are ignored; req is only sampled in IDLE.
  - Requester i re-requesting immediately after ack while another requester is waiting: the other requester wins, because the pointer has advanced.
  - All NREQ requesting continuously: strict rotation 0, 1, ..., NREQ-1, 0.
  - Pointer wrap: granting index NREQ-1 sets the pointer to 0.
- Arithmetic: none in this block. Results and flags are passed through unmodified.

Optional Feature:
- Macro: ALU_ARB_TIMEOUT_EN.
- Defined:
  - A counter of width clog2(TIMEOUT+1) clears on entry to RESP and increments each RESP cycle without ack.
  - When it reaches TIMEOUT with no ack, rsp_valid clears, err sets (sticky until reset), the pointer advances as for an ack, and state goes to IDLE.
  - An ack arriving in the same cycle the counter hits TIMEOUT is honoured as a normal ack; err does not set.
- Undefined:
  - No counter is built; RESP waits indefinitely.
  - err is a constant 0.

Decomposition:
- cpu_types_pkg: reuse word_t and aluop_t. Add alu_arb_state_t enum {IDLE, EXEC, RESP}.
- Sub-module rr_pick: combinational round-robin one-hot picker with inputs req and ptr, outputs gnt_oh and gnt_idx, parameterised by NREQ.

Test Plan:
- Reset then single request: nRST low for 2 cycles, then req[0]=1 with ALU_ADD, a=32'h0000_0005, b=32'h0000_0003 at cycle t. Expect gnt[0] at t, rsp_valid[0] at t+2, rsp_data=32'h8, zero=0; ack drops rsp_valid on the next edge.
- Contention: req[0] and req[1] held high permanently with ALU_SUB, a=b=32'h7. Expect grant order 0,1,0,1, each response 0 with zero=1, and 3 cycles between grants.
- Held response: ack withheld for 10 cycles after a signed overflow (ALU_ADD, 32'h7FFF_FFFF + 32'h1). Expect rsp_data=32'h8000_0000 with neg=1 and ovf=1, stable all 10 cycles. A wrong-index ack (rsp_ack[1]) has no effect.
- Reset mid-operation: nRST low during EXEC. Expect no rsp_valid, busy=0 next cycle, and the next grant goes to requester 0 even if the pointer was at 1.
- Simultaneous events: ack in the first RESP cycle while req[1] is high. Expect IDLE next cycle with gnt[1], then rsp_valid[1] two cycles later.
- With ALU_ARB_TIMEOUT_EN and TIMEOUT=4, no ack: expect rsp_valid to fall after 4 RESP cycles, err=1 and held, and the pointer advanced. Repeat with ack on the 4th cycle: err stays 0.

Source files
------------

// File: rtl/alu_share_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_share_arb_pkg
// Description : Shared types for the ALU sharing arbiter. It carries the
//               word_t and aluop_t types of the CPU type set and adds the
//               arbiter state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_share_arb_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [3:0] {
    ALU_SLL = 4'h0,
    ALU_SRL = 4'h1,
    ALU_SRA = 4'h2,
    ALU_ADD = 4'h3,
    ALU_SUB = 4'h4,
    ALU_AND = 4'h5,
    ALU_OR  = 4'h6,
    ALU_XOR = 4'h7,
    ALU_NOR = 4'h8,
    ALU_SLT = 4'h9,
    ALU_SLTU = 4'hA
  } aluop_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } alu_arb_state_t;

endpackage
`default_nettype wire

// File: rtl/alu_share_arb_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_share_arb_if
// Description : Bus bundle between the requesters, the arbiter and the ALU.
//   Requester side : req, req_op, req_a, req_b, gnt, rsp_valid, rsp_ack,
//                    rsp_data, rsp_neg, rsp_ovf, rsp_zero, busy, err
//   ALU side       : alu_op, alu_a, alu_b (to ALU); alu_out, alu_neg,
//                    alu_ovf, alu_zero (from ALU)
//   Modports       : slave  - the arbiter
//                    master - the environment (requesters plus ALU)
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_share_arb_if
  import alu_share_arb_pkg::*;
#(
  parameter int NREQ = 2
);

  logic [NREQ-1:0] req;
  aluop_t          req_op [NREQ];
  word_t           req_a  [NREQ];
  word_t           req_b  [NREQ];
  logic [NREQ-1:0] gnt;
  logic [NREQ-1:0] rsp_valid;
  logic [NREQ-1:0] rsp_ack;
  word_t           rsp_data;
  logic            rsp_neg;
  logic            rsp_ovf;
  logic            rsp_zero;
  logic            busy;
  logic            err;
  aluop_t          alu_op;
  word_t           alu_a;
  word_t           alu_b;
  word_t           alu_out;
  logic            alu_neg;
  logic            alu_ovf;
  logic            alu_zero;

  modport slave (
    input  req, req_op, req_a, req_b, rsp_ack,
    input  alu_out, alu_neg, alu_ovf, alu_zero,
    output gnt, rsp_valid, rsp_data, rsp_neg, rsp_ovf, rsp_zero, busy, err,
    output alu_op, alu_a, alu_b
  );

  modport master (
    output req, req_op, req_a, req_b, rsp_ack,
    output alu_out, alu_neg, alu_ovf, alu_zero,
    input  gnt, rsp_valid, rsp_data, rsp_neg, rsp_ovf, rsp_zero, busy, err,
    input  alu_op, alu_a, alu_b
  );

endinterface
`default_nettype wire

// File: rtl/alu_share_arb_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin picker. Returns the first set
//               request at or after ptr, wrapping modulo NREQ.
//   req     in  NREQ   request vector
//   ptr     in  IDXW   starting index of the search
//   gnt_oh  out NREQ   one-hot winner (all zero when no request)
//   gnt_idx out IDXW   index of the winner (0 when no request)
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick #(
  parameter  int NREQ = 2,
  localparam int IDXW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDXW-1:0] ptr,
  output logic [NREQ-1:0] gnt_oh,
  output logic [IDXW-1:0] gnt_idx
);

  logic w_found;
  int   w_cand;

  always_comb begin
    gnt_oh  = '0;
    gnt_idx = '0;
    w_found = 1'b0;
    w_cand  = 0;
    for (int k = 0; k < NREQ; k++) begin
      w_cand = int'(ptr) + k;
      if (w_cand >= NREQ) begin
        w_cand = w_cand - NREQ;
      end
      if (!w_found && req[w_cand]) begin
        w_found = 1'b1;
        gnt_oh  = NREQ'(1) << w_cand;
        gnt_idx = IDXW'(w_cand);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_share_arb.sv
`default_nettype none
// ============================================================================
// Module      : alu_share_arb
// Description : Shares one combinational ALU between NREQ requesters with
//               round-robin arbitration. Operands are registered at grant,
//               the ALU settles for one cycle, and the result plus flags are
//               held until the owning requester acknowledges.
//   CLK  in   system clock
//   nRST in   synchronous active-low reset
//   bus  slave modport of alu_share_arb_if (requester and ALU signals)
// Optional    : ALU_ARB_TIMEOUT_EN - abandon an unacknowledged response
//               after TIMEOUT RESP cycles and set the sticky err flag.
//               Without it, RESP waits indefinitely and err is 0.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_share_arb
  import alu_share_arb_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 15
) (
  input  logic           CLK,
  input  logic           nRST,
  alu_share_arb_if.slave bus
);

  localparam int IDXW = $clog2(NREQ);

  alu_arb_state_t  r_state;
  alu_arb_state_t  w_state_nxt;
  logic [IDXW-1:0] r_ptr;
  logic [IDXW-1:0] r_idx;
  logic [IDXW-1:0] w_pick_idx;
  logic [NREQ-1:0] w_pick_oh;
  logic            w_any_req;
  logic            w_ack;
  logic            w_timeout;
  logic            w_release;
  logic [IDXW-1:0] w_idx_inc;

  aluop_t          r_alu_op;
  word_t           r_alu_a;
  word_t           r_alu_b;
  word_t           r_rsp_data;
  logic            r_rsp_neg;
  logic            r_rsp_ovf;
  logic            r_rsp_zero;
  logic [NREQ-1:0] r_rsp_valid;

  rr_pick #(
    .NREQ    (NREQ)
  ) u_rr_pick (
    .req     (bus.req),
    .ptr     (r_ptr),
    .gnt_oh  (w_pick_oh),
    .gnt_idx (w_pick_idx)
  );

  assign w_any_req = |bus.req;
  // Only the owner's ack bit counts, and only while a response is held.
  assign w_ack     = (r_state == RESP) && bus.rsp_ack[r_idx];
  assign w_release = w_ack || w_timeout;
  assign w_idx_inc = (r_idx == IDXW'(NREQ - 1)) ? '0 : r_idx + IDXW'(1);

  // State register
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_any_req) w_state_nxt = EXEC;
      EXEC:    w_state_nxt = RESP;
      RESP:    if (w_release) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Operand, response and pointer registers
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_ptr       <= '0;
      r_idx       <= '0;
      r_alu_op    <= aluop_t'(4'h0);
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_rsp_data  <= '0;
      r_rsp_neg   <= 1'b0;
      r_rsp_ovf   <= 1'b0;
      r_rsp_zero  <= 1'b0;
      r_rsp_valid <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any_req) begin
            r_idx    <= w_pick_idx;
            r_alu_op <= bus.req_op[w_pick_idx];
            r_alu_a  <= bus.req_a[w_pick_idx];
            r_alu_b  <= bus.req_b[w_pick_idx];
          end
        end
        EXEC: begin
          r_rsp_data  <= bus.alu_out;
          r_rsp_neg   <= bus.alu_neg;
          r_rsp_ovf   <= bus.alu_ovf;
          r_rsp_zero  <= bus.alu_zero;
          r_rsp_valid <= NREQ'(1) << r_idx;
        end
        RESP: begin
          if (w_release) begin
            r_rsp_valid <= '0;
            r_ptr       <= w_idx_inc;
          end
        end
        default: begin
          r_rsp_valid <= '0;
        end
      endcase
    end
  end

`ifdef ALU_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] r_tcnt;
  logic          r_err;

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_tcnt <= '0;
      r_err  <= 1'b0;
    end else begin
      if (r_state == EXEC) begin
        r_tcnt <= '0;
      end else if ((r_state == RESP) && !w_ack) begin
        r_tcnt <= r_tcnt + TW'(1);
      end
      if (w_timeout) begin
        r_err <= 1'b1;
      end
    end
  end

  // Fires on the edge at which the count would reach TIMEOUT, so exactly
  // TIMEOUT RESP cycles are offered; a coincident ack takes precedence.
  assign w_timeout = (r_state == RESP) && !w_ack && (r_tcnt == TW'(TIMEOUT - 1));
  assign bus.err   = r_err;
`else
  assign w_timeout = 1'b0;
  assign bus.err   = 1'b0;
`endif

  // Grant is a combinational pulse in the IDLE cycle that loads the operands;
  // held off while reset is asserted so no phantom grant is seen.
  assign bus.gnt       = ((r_state == IDLE) && nRST) ? w_pick_oh : '0;
  assign bus.busy      = (r_state != IDLE);
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_data  = r_rsp_data;
  assign bus.rsp_neg   = r_rsp_neg;
  assign bus.rsp_ovf   = r_rsp_ovf;
  assign bus.rsp_zero  = r_rsp_zero;
  assign bus.alu_op    = r_alu_op;
  assign bus.alu_a     = r_alu_a;
  assign bus.alu_b     = r_alu_b;

endmodule
`default_nettype wire

// File: tb/tb_alu_share_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_share_arb
// Description : Directed self-checking bench for alu_share_arb with two
//               requesters and a small behavioural ALU attached to the ALU
//               port. With ALU_ARB_TIMEOUT_EN defined it also exercises the
//               response timeout (TIMEOUT = 4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_share_arb;
  import alu_share_arb_pkg::*;

  logic CLK;
  logic nRST;
  int   n_assert;
  int   n_fail;

  alu_share_arb_if #(.NREQ(2)) bus ();

  alu_share_arb #(
    .NREQ    (2),
    .TIMEOUT (4)
  ) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Behavioural ALU driven by the arbiter's registered operands.
  word_t w_sum;
  always_comb begin
    w_sum       = '0;
    bus.alu_ovf = 1'b0;
    case (bus.alu_op)
      ALU_ADD: begin
        w_sum       = bus.alu_a + bus.alu_b;
        bus.alu_ovf = (bus.alu_a[31] == bus.alu_b[31]) && (w_sum[31] != bus.alu_a[31]);
      end
      ALU_SUB: begin
        w_sum       = bus.alu_a - bus.alu_b;
        bus.alu_ovf = (bus.alu_a[31] != bus.alu_b[31]) && (w_sum[31] != bus.alu_a[31]);
      end
      default: w_sum = '0;
    endcase
    bus.alu_out  = w_sum;
    bus.alu_neg  = w_sum[31];
    bus.alu_zero = (w_sum == '0);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_assert       = 0;
    n_fail         = 0;
    nRST           = 1'b0;
    bus.req        = '0;
    bus.rsp_ack    = '0;
    bus.req_op[0]  = ALU_ADD;
    bus.req_op[1]  = ALU_ADD;
    bus.req_a[0]   = '0;
    bus.req_a[1]   = '0;
    bus.req_b[0]   = '0;
    bus.req_b[1]   = '0;

    // ---------------- reset ----------------
    cyc();
    cyc();
    chk("rst_busy", bus.busy, 0);
    chk("rst_gnt", bus.gnt, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_data", bus.rsp_data, 0);
    chk("rst_alu_op", bus.alu_op, 0);
    chk("rst_alu_a", bus.alu_a, 0);
    chk("rst_err", bus.err, 0);
    nRST = 1'b1;
    cyc();

    // ---------------- single request: 5 + 3 ----------------
    bus.req       = 2'b01;
    bus.req_op[0] = ALU_ADD;
    bus.req_a[0]  = 32'h0000_0005;
    bus.req_b[0]  = 32'h0000_0003;
    #1;
    chk("single_gnt_t", bus.gnt, 2'b01);
    cyc();
    bus.req = 2'b00;
    #1;
    chk("single_busy_exec", bus.busy, 1);
    chk("single_gnt_exec", bus.gnt, 0);
    chk("single_valid_exec", bus.rsp_valid, 0);
    chk("single_alu_a", bus.alu_a, 32'h5);
    chk("single_alu_b", bus.alu_b, 32'h3);
    chk("single_alu_op", bus.alu_op, ALU_ADD);
    cyc();
    chk("single_valid_t2", bus.rsp_valid, 2'b01);
    chk("single_data", bus.rsp_data, 32'h8);
    chk("single_zero", bus.rsp_zero, 0);
    bus.rsp_ack = 2'b01;
    cyc();
    bus.rsp_ack = 2'b00;
    chk("single_valid_after_ack", bus.rsp_valid, 0);
    chk("single_busy_after_ack", bus.busy, 0);

    // ---------------- contention: pointer now at 1 -> 1,0,1,0 ----------------
    bus.req       = 2'b11;
    bus.req_op[0] = ALU_SUB;
    bus.req_op[1] = ALU_SUB;
    bus.req_a[0]  = 32'h7;
    bus.req_b[0]  = 32'h7;
    bus.req_a[1]  = 32'h7;
    bus.req_b[1]  = 32'h7;
    for (int k = 0; k < 4; k++) begin
      logic [1:0] exp_oh;
      exp_oh = (k % 2 == 0) ? 2'b10 : 2'b01;
      #1;
      chk("cont_gnt", bus.gnt, exp_oh);
      cyc();
      chk("cont_gnt_exec", bus.gnt, 0);
      cyc();
      chk("cont_gnt_resp", bus.gnt, 0);
      chk("cont_valid", bus.rsp_valid, exp_oh);
      chk("cont_data", bus.rsp_data, 0);
      chk("cont_zero", bus.rsp_zero, 1);
      bus.rsp_ack = exp_oh;
      cyc();
      bus.rsp_ack = 2'b00;
    end
    bus.req = 2'b00;
    #1;
    chk("cont_idle_after", bus.busy, 0);

    // ---------------- held response with overflow, pointer at 1 ----------------
    bus.req       = 2'b01;
    bus.req_op[0] = ALU_ADD;
    bus.req_a[0]  = 32'h7FFF_FFFF;
    bus.req_b[0]  = 32'h0000_0001;
    #1;
    chk("held_gnt_wrap", bus.gnt, 2'b01);
    cyc();
    bus.req     = 2'b00;
    bus.rsp_ack = 2'b01;   // ack outside RESP must be ignored
    cyc();
    bus.rsp_ack = 2'b10;   // wrong index must be ignored
    chk("held_neg", bus.rsp_neg, 1);
    chk("held_ovf", bus.rsp_ovf, 1);
    for (int k = 0; k < 10; k++) begin
      chk("held_valid", bus.rsp_valid, 2'b01);
      chk("held_data", bus.rsp_data, 32'h8000_0000);
      cyc();
    end
    chk("held_valid_last", bus.rsp_valid, 2'b01);
    chk("held_err", bus.err, 0);
    bus.rsp_ack = 2'b01;
    cyc();
    bus.rsp_ack = 2'b00;
    chk("held_valid_clr", bus.rsp_valid, 0);

    // ---------------- reset during EXEC, pointer at 1 ----------------
    bus.req       = 2'b10;
    bus.req_op[1] = ALU_ADD;
    bus.req_a[1]  = 32'h10;
    bus.req_b[1]  = 32'h20;
    #1;
    chk("rstmid_gnt", bus.gnt, 2'b10);
    cyc();
    chk("rstmid_busy_exec", bus.busy, 1);
    nRST    = 1'b0;
    bus.req = 2'b00;
    cyc();
    nRST = 1'b1;
    #1;
    chk("rstmid_busy", bus.busy, 0);
    chk("rstmid_valid", bus.rsp_valid, 0);
    chk("rstmid_data", bus.rsp_data, 0);
    bus.req       = 2'b11;
    bus.req_op[0] = ALU_ADD;
    bus.req_a[0]  = 32'h1;
    bus.req_b[0]  = 32'h1;
    #1;
    chk("rstmid_gnt_ptr0", bus.gnt, 2'b01);
    cyc();
    cyc();
    chk("rstmid_valid0", bus.rsp_valid, 2'b01);
    chk("rstmid_data0", bus.rsp_data, 32'h2);

    // ---------------- ack in first RESP cycle with req[1] waiting ----------------
    bus.req     = 2'b10;
    bus.rsp_ack = 2'b01;
    cyc();
    bus.rsp_ack = 2'b00;
    #1;
    chk("simul_busy", bus.busy, 0);
    chk("simul_gnt1", bus.gnt, 2'b10);
    cyc();
    bus.req = 2'b00;
    chk("simul_valid_exec", bus.rsp_valid, 0);
    cyc();
    chk("simul_valid1", bus.rsp_valid, 2'b10);
    chk("simul_data1", bus.rsp_data, 32'h30);
    bus.rsp_ack = 2'b10;
    cyc();
    bus.rsp_ack = 2'b00;
    chk("simul_valid_clr", bus.rsp_valid, 0);

`ifdef ALU_ARB_TIMEOUT_EN
    // ---------------- ack on 4th RESP cycle: no error ----------------
    bus.req = 2'b01;
    #1;
    chk("to_ack_gnt", bus.gnt, 2'b01);
    cyc();
    bus.req = 2'b00;
    cyc();
    for (int k = 0; k < 3; k++) begin
      chk("to_ack_valid", bus.rsp_valid, 2'b01);
      cyc();
    end
    chk("to_ack_valid4", bus.rsp_valid, 2'b01);
    bus.rsp_ack = 2'b01;
    cyc();
    bus.rsp_ack = 2'b00;
    chk("to_ack_clr", bus.rsp_valid, 0);
    chk("to_ack_err", bus.err, 0);

    // ---------------- no ack: abandon after 4 RESP cycles ----------------
    bus.req = 2'b10;
    #1;
    chk("to_gnt", bus.gnt, 2'b10);
    cyc();
    bus.req = 2'b00;
    cyc();
    for (int k = 0; k < 4; k++) begin
      chk("to_valid", bus.rsp_valid, 2'b10);
      cyc();
    end
    chk("to_valid_fall", bus.rsp_valid, 0);
    chk("to_err", bus.err, 1);
    chk("to_busy", bus.busy, 0);
    cyc();
    chk("to_err_held", bus.err, 1);
    bus.req = 2'b11;
    #1;
    chk("to_ptr_adv", bus.gnt, 2'b01);
    cyc();
    bus.req = 2'b00;
    cyc();
    bus.rsp_ack = 2'b01;
    cyc();
    bus.rsp_ack = 2'b00;
`else
    cyc();
    chk("no_to_err", bus.err, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
